// File: rtl/seg7_pkg.sv
// seg7 scan controller shared types and helpers.
// Polarity helper, pattern type and default sizes.
package seg7_pkg;

  typedef logic [7:0] seg7_pat_t;

  localparam int N_DIG_DEF     = 4;
  localparam int SLOT_LOG2_DEF = 10;
  localparam int BR_W_DEF      = 4;

  function automatic seg7_pat_t apply_pol(
    input seg7_pat_t v,
    input logic      act_low
  );
    return act_low ? ~v : v;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot position / digit index counters for the scanner.
// Flags dead-time cycle, frame end and the PWM compare.
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int N_DIG     = N_DIG_DEF,
  parameter int SLOT_LOG2 = SLOT_LOG2_DEF,
  parameter int BR_W      = BR_W_DEF,
  parameter int DW        = $clog2(N_DIG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BR_W-1:0] bright,
  output logic [DW-1:0]   d,
  output logic            slot_first,
  output logic            frame_end,
  output logic            pwm_on
);

  logic [SLOT_LOG2-1:0] p_q, p_d;
  logic [DW-1:0]        d_q, d_d;
  logic                 p_last;
  logic                 d_last;

  // next counter values and status flags
  always_comb begin
    p_last     = &p_q;
    d_last     = (d_q == DW'(N_DIG - 1));
    p_d        = p_q + 1'b1;
    d_d        = d_q;
    if (p_last) begin
      d_d = d_last ? '0 : d_q + 1'b1;
    end
    slot_first = (p_q == '0);
    frame_end  = p_last && d_last;
    pwm_on     = (p_q[SLOT_LOG2-1 -: BR_W] <= bright);
    d          = d_q;
  end

  // counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= '0;
      d_q <= '0;
    end else begin
      p_q <= p_d;
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner with PWM and dead time.
// Updates are staged and swapped in at frame boundaries.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIG       = N_DIG_DEF,
  parameter int SLOT_LOG2   = SLOT_LOG2_DEF,
  parameter int BR_W        = BR_W_DEF,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [N_DIG*8-1:0] upd_seg,
  input  logic [N_DIG-1:0]   upd_en,
  input  logic [BR_W-1:0]    upd_bright,
  output logic               frame_done,
  output logic [7:0]         seg,
  output logic [N_DIG-1:0]   dig
);

  localparam int DW = $clog2(N_DIG);
  localparam seg7_pat_t SEG_OFF = apply_pol(8'h00, SEG_ACT_LOW);
  localparam logic [N_DIG-1:0] DIG_OFF = {N_DIG{DIG_ACT_LOW}};

  logic                 pend_q, pend_d;
  logic [N_DIG*8-1:0]   pnd_seg_q, pnd_seg_d;
  logic [N_DIG-1:0]     pnd_en_q, pnd_en_d;
  logic [BR_W-1:0]      pnd_br_q, pnd_br_d;
  logic [N_DIG*8-1:0]   act_seg_q, act_seg_d;
  logic [N_DIG-1:0]     act_en_q, act_en_d;
  logic [BR_W-1:0]      act_br_q, act_br_d;
  seg7_pat_t            seg_q, seg_d;
  logic [N_DIG-1:0]     dig_q, dig_d;
  logic                 fd_q, fd_d;

  logic [DW-1:0]        d;
  logic                 slot_first;
  logic                 frame_end;
  logic                 pwm_on;
  logic                 accept;
  logic                 lit;
  seg7_pat_t            seg_raw;
  logic [N_DIG-1:0]     dig_raw;

  seg7_scan_timer #(
    .N_DIG    (N_DIG),
    .SLOT_LOG2(SLOT_LOG2),
    .BR_W     (BR_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .bright    (act_br_q),
    .d         (d),
    .slot_first(slot_first),
    .frame_end (frame_end),
    .pwm_on    (pwm_on)
  );

  // handshake, pending capture and frame-boundary swap
  always_comb begin
    upd_ready = !pend_q;
    accept    = upd_valid && !pend_q;
    pend_d    = pend_q;
    pnd_seg_d = pnd_seg_q;
    pnd_en_d  = pnd_en_q;
    pnd_br_d  = pnd_br_q;
    act_seg_d = act_seg_q;
    act_en_d  = act_en_q;
    act_br_d  = act_br_q;
    if (frame_end && pend_q) begin
      act_seg_d = pnd_seg_q;
      act_en_d  = pnd_en_q;
      act_br_d  = pnd_br_q;
      pend_d    = 1'b0;
    end else if (accept) begin
      pnd_seg_d = upd_seg;
      pnd_en_d  = upd_en;
      pnd_br_d  = upd_bright;
      pend_d    = 1'b1;
    end
  end

  // lit decision and pin polarity
  always_comb begin
    lit     = !slot_first && pwm_on && act_en_q[d];
    seg_raw = '0;
    dig_raw = '0;
    if (lit) begin
      seg_raw    = act_seg_q[{d, 3'b000} +: 8];
      dig_raw[d] = 1'b1;
    end
    seg_d = apply_pol(seg_raw, SEG_ACT_LOW);
    dig_d = DIG_ACT_LOW ? ~dig_raw : dig_raw;
    fd_d  = frame_end;
  end

  // register state and output pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= 1'b0;
      pnd_seg_q <= '0;
      pnd_en_q  <= '0;
      pnd_br_q  <= '0;
      act_seg_q <= '0;
      act_en_q  <= '0;
      act_br_q  <= '0;
      seg_q     <= SEG_OFF;
      dig_q     <= DIG_OFF;
      fd_q      <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      pnd_seg_q <= pnd_seg_d;
      pnd_en_q  <= pnd_en_d;
      pnd_br_q  <= pnd_br_d;
      act_seg_q <= act_seg_d;
      act_en_q  <= act_en_d;
      act_br_q  <= act_br_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
      fd_q      <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dig        = dig_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl.
// Instance A: 4 digits, 4-cycle slots; B: 6 digits, 16-cycle slots.
module tb_seg7_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance A: N_DIG=4, SLOT_LOG2=2, BR_W=2, seg active-high
  logic        a_rst, a_valid, a_ready, a_fd;
  logic [31:0] a_useg;
  logic [3:0]  a_uen, a_dig;
  logic [1:0]  a_ubr;
  logic [7:0]  a_seg;

  seg7_scan_ctrl #(
    .N_DIG(4), .SLOT_LOG2(2), .BR_W(2),
    .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b1)
  ) dut_a (
    .clk(clk), .rst(a_rst),
    .upd_valid(a_valid), .upd_ready(a_ready),
    .upd_seg(a_useg), .upd_en(a_uen), .upd_bright(a_ubr),
    .frame_done(a_fd), .seg(a_seg), .dig(a_dig)
  );

  // instance B: N_DIG=6, SLOT_LOG2=4, BR_W=2, seg active-low
  logic        b_rst, b_valid, b_ready, b_fd;
  logic [47:0] b_useg;
  logic [5:0]  b_uen, b_dig;
  logic [1:0]  b_ubr;
  logic [7:0]  b_seg;

  seg7_scan_ctrl #(
    .N_DIG(6), .SLOT_LOG2(4), .BR_W(2),
    .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)
  ) dut_b (
    .clk(clk), .rst(b_rst),
    .upd_valid(b_valid), .upd_ready(b_ready),
    .upd_seg(b_useg), .upd_en(b_uen), .upd_bright(b_ubr),
    .frame_done(b_fd), .seg(b_seg), .dig(b_dig)
  );

  typedef struct {
    logic [3:0] dig;
    logic [7:0] seg;
    logic       fd;
  } vec_a_t;

  vec_a_t tab3 [16];
  vec_a_t tab4 [10];
  logic [7:0] pat_b [6];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string nm, input vec_a_t v);
    chk({nm, " dig"}, 32'(a_dig), 32'(v.dig));
    chk({nm, " seg"}, 32'(a_seg), 32'(v.seg));
    chk({nm, " fd"},  32'(a_fd),  32'(v.fd));
  endtask

  // one full frame of B; expected lit when p in 1..lim and en[d]
  task automatic run_frame_b(input string nm, input int lim,
                             input logic [5:0] en,
                             input int up_at, input int dn_at);
    int cnt [6];
    int d, p;
    logic lit;
    logic [5:0] ed;
    logic [7:0] es;
    for (int i = 0; i < 6; i++) cnt[i] = 0;
    for (int s = 0; s < 96; s++) begin
      tick();
      d   = s / 16;
      p   = s % 16;
      lit = (p != 0) && (p <= lim) && en[d];
      ed  = lit ? ~(6'b1 << d) : 6'h3F;
      es  = lit ? ~pat_b[d] : 8'hFF;
      if (b_dig !== 6'h3F) cnt[d]++;
      chk($sformatf("%s s%0d dig", nm, s), 32'(b_dig), 32'(ed));
      chk($sformatf("%s s%0d seg", nm, s), 32'(b_seg), 32'(es));
      chk($sformatf("%s s%0d fd", nm, s), 32'(b_fd), 32'(s == 95));
      if (s == up_at) b_valid = 1'b1;
      if (s == dn_at) b_valid = 1'b0;
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s litcnt d%0d", nm, i), 32'(cnt[i]),
          en[i] ? 32'(lim) : 32'd0);
  endtask

  initial begin
    // frame 3: all digits, full brightness
    tab3 = '{
      '{4'hF, 8'h00, 1'b0}, '{4'hE, 8'h4F, 1'b0},
      '{4'hE, 8'h4F, 1'b0}, '{4'hE, 8'h4F, 1'b0},
      '{4'hF, 8'h00, 1'b0}, '{4'hD, 8'h5B, 1'b0},
      '{4'hD, 8'h5B, 1'b0}, '{4'hD, 8'h5B, 1'b0},
      '{4'hF, 8'h00, 1'b0}, '{4'hB, 8'h06, 1'b0},
      '{4'hB, 8'h06, 1'b0}, '{4'hB, 8'h06, 1'b0},
      '{4'hF, 8'h00, 1'b0}, '{4'h7, 8'h3F, 1'b0},
      '{4'h7, 8'h3F, 1'b0}, '{4'h7, 8'h3F, 1'b1}
    };
    // frame 4: en=0101, b=1 -> only p=1 lit
    tab4 = '{
      '{4'hF, 8'h00, 1'b0}, '{4'hE, 8'h4F, 1'b0},
      '{4'hF, 8'h00, 1'b0}, '{4'hF, 8'h00, 1'b0},
      '{4'hF, 8'h00, 1'b0}, '{4'hF, 8'h00, 1'b0},
      '{4'hF, 8'h00, 1'b0}, '{4'hF, 8'h00, 1'b0},
      '{4'hF, 8'h00, 1'b0}, '{4'hB, 8'h06, 1'b0}
    };
    pat_b = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D};

    a_rst = 1'b1; a_valid = 1'b0;
    a_useg = '0; a_uen = '0; a_ubr = '0;
    b_rst = 1'b1; b_valid = 1'b0;
    b_useg = '0; b_uen = '0; b_ubr = '0;

    // ---- A: reset state and idle first frame
    #3;
    chk("a rst dig", 32'(a_dig), 32'hF);
    chk("a rst seg", 32'(a_seg), 32'h0);
    chk("a rst fd", 32'(a_fd), 32'h0);
    @(negedge clk);
    a_rst = 1'b0;
    #1;
    chk("a rst ready", 32'(a_ready), 32'h1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("a idle e%0d dig", k), 32'(a_dig), 32'hF);
      chk($sformatf("a idle e%0d seg", k), 32'(a_seg), 32'h0);
      chk($sformatf("a idle e%0d fd", k), 32'(a_fd), 32'(k == 16));
    end

    // ---- A: first update accepted at edge 17
    a_useg = {8'h3F, 8'h06, 8'h5B, 8'h4F};
    a_uen = 4'hF; a_ubr = 2'd3; a_valid = 1'b1;
    tick();
    chk("a acc1 ready", 32'(a_ready), 32'h0);
    // second request held, different content
    a_uen = 4'b0101; a_ubr = 2'd1;
    for (int k = 18; k <= 31; k++) begin
      tick();
      chk($sformatf("a wait e%0d dig", k), 32'(a_dig), 32'hF);
      chk($sformatf("a wait e%0d ready", k), 32'(a_ready), 32'h0);
    end
    tick();
    chk("a e32 fd", 32'(a_fd), 32'h1);
    chk("a e32 dig", 32'(a_dig), 32'hF);
    chk("a e32 ready", 32'(a_ready), 32'h1);

    // ---- A: frame 3 shows update 1; second accepted at edge 33
    for (int j = 0; j < 16; j++) begin
      tick();
      if (j == 0) begin
        chk("a acc2 ready", 32'(a_ready), 32'h0);
        a_valid = 1'b0;
      end
      chk_a($sformatf("a f3 j%0d", j), tab3[j]);
    end
    chk("a e48 ready", 32'(a_ready), 32'h1);

    // ---- A: frame 4 shows update 2; third update then reset
    a_uen = 4'hF; a_ubr = 2'd3;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk_a($sformatf("a f4 j%0d", j), tab4[j]);
      if (j == 0) a_valid = 1'b1;
      if (j == 1) begin
        chk("a acc3 ready", 32'(a_ready), 32'h0);
        a_valid = 1'b0;
      end
    end
    #2;
    a_rst = 1'b1;
    #1;
    chk("a mid rst dig", 32'(a_dig), 32'hF);
    chk("a mid rst seg", 32'(a_seg), 32'h0);
    chk("a mid rst ready", 32'(a_ready), 32'h1);
    @(negedge clk);
    a_rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("a post e%0d dig", k), 32'(a_dig), 32'hF);
      chk($sformatf("a post e%0d seg", k), 32'(a_seg), 32'h0);
      chk($sformatf("a post e%0d fd", k), 32'(a_fd), 32'(k == 16));
    end

    // ---- B: 6 digits, active-low seg
    #3;
    chk("b rst dig", 32'(b_dig), 32'h3F);
    chk("b rst seg", 32'(b_seg), 32'hFF);
    b_useg = {pat_b[5], pat_b[4], pat_b[3],
              pat_b[2], pat_b[1], pat_b[0]};
    b_uen = 6'h3F; b_ubr = 2'd1; b_valid = 1'b1;
    @(negedge clk);
    b_rst = 1'b0;
    run_frame_b("b f0", 0, 6'h00, -1, 0);
    chk("b f0 ready", 32'(b_ready), 32'h1);
    b_ubr = 2'd0;
    run_frame_b("b f1", 7, 6'h3F, 3, 4);
    chk("b f1 ready", 32'(b_ready), 32'h1);
    b_uen = 6'h00;
    run_frame_b("b f2", 3, 6'h3F, 94, 95);
    chk("b f2 ready", 32'(b_ready), 32'h0);
    run_frame_b("b f3", 3, 6'h3F, -1, -1);
    chk("b f3 ready", 32'(b_ready), 32'h1);
    run_frame_b("b f4", 0, 6'h00, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
